io_input_cond: RTL and testbench



---
 rtl/io_pkg.sv | 16 +
 rtl/debounce_bit.sv | 67 ++++++
 rtl/io_input_cond.sv | 77 +++++++
 tb/tb_io_input_cond.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: constants shared by the board input-conditioning path and the LSU.
//   IO_WORD_W        width of the LSU I/O input words
//   DEF_SYNC_STAGES  default synchroniser depth
//   DEF_DB_CYCLES    default debounce qualification time (10 ms at 50 MHz)
//   IO_SW_ADDR       LSU address of the switch word
//   IO_BTN_ADDR      LSU address of the button word
package io_pkg;

    localparam int unsigned IO_WORD_W       = 32;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_DB_CYCLES   = 500000;

    localparam logic [IO_WORD_W-1:0] IO_SW_ADDR  = 32'h0000_7800;
    localparam logic [IO_WORD_W-1:0] IO_BTN_ADDR = 32'h0000_7810;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one conditioned input channel.
//   Synchronises an asynchronous level, then only accepts a new level once the
//   synchronised value has differed from the held level for DB_CYCLES
//   consecutive edges. Any return to the held level restarts the count.
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-high reset
//   i_raw    raw asynchronous level (already polarity-corrected)
//   o_level  debounced level
//   o_rise   one-cycle pulse on the edge o_level goes 0->1
//   o_fall   one-cycle pulse on the edge o_level goes 1->0
module debounce_bit #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   s;
    logic                   accept;

    assign s      = sync_q[SYNC_STAGES-1];
    // Final qualifying edge: level flips and the pulse registers on this same edge.
    assign accept = (s != level_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            o_rise <= accept & s;
            o_fall <= accept & ~s;
            if (s == level_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                level_q <= s;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_level = level_q;

endmodule

// File: rtl/io_input_cond.sv
// io_input_cond: board switch/button conditioning ahead of the LSU I/O window.
//   Every switch and button bit gets its own synchroniser and debouncer.
//   Buttons are inverted first when BTN_ACTIVE_LOW so that pressed reads 1.
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_sw_raw       raw switch pins (N_SW)
//   i_btn_raw      raw button pins (N_BTN)
//   o_io_sw        debounced switches, zero-extended to 32 bits
//   o_io_btn       debounced buttons (1 = pressed), zero-extended to 32 bits
//   o_btn_press    per-button one-cycle pulse on debounced press
//   o_btn_release  per-button one-cycle pulse on debounced release
//   o_sw_change    one-cycle pulse when any debounced switch bit changes
module io_input_cond
    import io_pkg::*;
#(
    parameter int unsigned N_SW           = 18,
    parameter int unsigned N_BTN          = 4,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned DB_CYCLES      = DEF_DB_CYCLES,
    parameter int unsigned BTN_ACTIVE_LOW = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_SW-1:0]      i_sw_raw,
    input  logic [N_BTN-1:0]     i_btn_raw,
    output logic [IO_WORD_W-1:0] o_io_sw,
    output logic [IO_WORD_W-1:0] o_io_btn,
    output logic [N_BTN-1:0]     o_btn_press,
    output logic [N_BTN-1:0]     o_btn_release,
    output logic                 o_sw_change
);

    logic [N_BTN-1:0] btn_pressed_raw;
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_rise;
    logic [N_SW-1:0]  sw_fall;
    logic [N_BTN-1:0] btn_level;

    assign btn_pressed_raw = (BTN_ACTIVE_LOW != 0) ? ~i_btn_raw : i_btn_raw;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_db (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (i_sw_raw[i]),
            .o_level (sw_level[i]),
            .o_rise  (sw_rise[i]),
            .o_fall  (sw_fall[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_db (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (btn_pressed_raw[i]),
            .o_level (btn_level[i]),
            .o_rise  (o_btn_press[i]),
            .o_fall  (o_btn_release[i])
        );
    end

    // Rise/fall are already registered per bit, so their OR is the registered
    // "any switch changed" flag and lines up with the o_io_sw update.
    assign o_sw_change = |(sw_rise | sw_fall);

    assign o_io_sw  = IO_WORD_W'(sw_level);
    assign o_io_btn = IO_WORD_W'(btn_level);

endmodule

// File: tb/tb_io_input_cond.sv
module tb_io_input_cond;

    logic        clk;
    logic        rst;
    logic [17:0] sw;
    logic [3:0]  btn;
    logic [31:0] io_sw;
    logic [31:0] io_btn;
    logic [3:0]  press;
    logic [3:0]  release_p;
    logic        sw_change;

    int total = 0;
    int bad   = 0;

    int pcnt[4];
    int rcnt[4];
    int swc;

    io_input_cond #(
        .N_SW           (18),
        .N_BTN          (4),
        .SYNC_STAGES    (2),
        .DB_CYCLES      (4),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sw_raw      (sw),
        .i_btn_raw     (btn),
        .o_io_sw       (io_sw),
        .o_io_btn      (io_btn),
        .o_btn_press   (press),
        .o_btn_release (release_p),
        .o_sw_change   (sw_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] sw;
        logic [3:0]  btn;
        int          n;
        logic [31:0] e_sw;
        logic [31:0] e_btn;
        logic [3:0]  e_press;
        logic [3:0]  e_rel;
        int          e_swc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [17:0] s, input logic [3:0] b, input int n,
                       input logic [31:0] es, input logic [31:0] eb,
                       input logic [3:0] ep, input logic [3:0] er, input int ec);
        vec_t v;
        v.sw = s; v.btn = b; v.n = n; v.e_sw = es; v.e_btn = eb;
        v.e_press = ep; v.e_rel = er; v.e_swc = ec;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            pcnt[i] = 0;
            rcnt[i] = 0;
        end
        swc = 0;
    endtask

    // Advance n edges, sampling 2 time units after each rising edge.
    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) begin
                if (press[i])     pcnt[i]++;
                if (release_p[i]) rcnt[i]++;
            end
            if (sw_change) swc++;
        end
    endtask

    // One hex nibble per button holding its pulse count.
    function automatic logic [31:0] pack_counts(input int c0, input int c1, input int c2, input int c3);
        return {16'h0, 4'(c3), 4'(c2), 4'(c1), 4'(c0)};
    endfunction

    function automatic logic [31:0] mask_to_counts(input logic [3:0] m);
        return {16'h0, 3'b0, m[3], 3'b0, m[2], 3'b0, m[1], 3'b0, m[0]};
    endfunction

    initial begin
        sw  = '0;
        btn = 4'hF;
        rst = 1'b1;
        clear_counts();

        #1;
        check("reset_io_sw", io_sw, 32'h0);
        check("reset_io_btn", io_btn, 32'h0);
        check("reset_pulses", {23'h0, press, release_p, sw_change}, 32'h0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // idle after reset
        add(18'h0,     4'hF, 20, 32'h0,     32'h0, 4'h0, 4'h0, 0);
        // switch 3 rises: not yet after edge 5, accepted at edge 6, pulse one cycle
        add(18'h8,     4'hF, 5,  32'h0,     32'h0, 4'h0, 4'h0, 0);
        add(18'h8,     4'hF, 1,  32'h8,     32'h0, 4'h0, 4'h0, 1);
        add(18'h8,     4'hF, 1,  32'h8,     32'h0, 4'h0, 4'h0, 0);
        // btn0 glitch of 3 cycles is rejected
        add(18'h8,     4'hE, 3,  32'h8,     32'h0, 4'h0, 4'h0, 0);
        add(18'h8,     4'hF, 10, 32'h8,     32'h0, 4'h0, 4'h0, 0);
        // btn0 held 4 cycles is accepted at edge 6, then released
        add(18'h8,     4'hE, 4,  32'h8,     32'h0, 4'h0, 4'h0, 0);
        add(18'h8,     4'hF, 2,  32'h8,     32'h1, 4'h1, 4'h0, 0);
        add(18'h8,     4'hF, 10, 32'h8,     32'h0, 4'h0, 4'h1, 0);
        // bouncy press on btn2: raw 0,1,0,0,1 then steady 0; press at edge 11
        add(18'h8,     4'hB, 1,  32'h8,     32'h0, 4'h0, 4'h0, 0);
        add(18'h8,     4'hF, 1,  32'h8,     32'h0, 4'h0, 4'h0, 0);
        add(18'h8,     4'hB, 1,  32'h8,     32'h0, 4'h0, 4'h0, 0);
        add(18'h8,     4'hB, 1,  32'h8,     32'h0, 4'h0, 4'h0, 0);
        add(18'h8,     4'hF, 1,  32'h8,     32'h0, 4'h0, 4'h0, 0);
        add(18'h8,     4'hB, 5,  32'h8,     32'h0, 4'h0, 4'h0, 0);
        add(18'h8,     4'hB, 1,  32'h8,     32'h4, 4'h4, 4'h0, 0);
        add(18'h8,     4'hB, 1,  32'h8,     32'h4, 4'h0, 4'h0, 0);
        add(18'h8,     4'hF, 10, 32'h8,     32'h0, 4'h0, 4'h4, 0);
        // sw0 and sw17 rise while sw3 falls on the same edge, btn1 pressed too
        add(18'h20001, 4'hD, 5,  32'h8,     32'h0, 4'h0, 4'h0, 0);
        add(18'h20001, 4'hD, 1,  32'h20001, 32'h2, 4'h2, 4'h0, 1);
        add(18'h20001, 4'hF, 8,  32'h20001, 32'h0, 4'h0, 4'h2, 0);

        foreach (tbl[k]) begin
            sw  = tbl[k].sw;
            btn = tbl[k].btn;
            clear_counts();
            run_cycles(tbl[k].n);
            check($sformatf("v%0d_io_sw", k), io_sw, tbl[k].e_sw);
            check($sformatf("v%0d_io_btn", k), io_btn, tbl[k].e_btn);
            check($sformatf("v%0d_press", k), pack_counts(pcnt[0], pcnt[1], pcnt[2], pcnt[3]),
                  mask_to_counts(tbl[k].e_press));
            check($sformatf("v%0d_release", k), pack_counts(rcnt[0], rcnt[1], rcnt[2], rcnt[3]),
                  mask_to_counts(tbl[k].e_rel));
            check($sformatf("v%0d_sw_change", k), 32'(swc), 32'(tbl[k].e_swc));
        end

        // reset mid-count on switch 4 (count reaches 2 after 4 edges)
        sw = 18'h20011;
        clear_counts();
        run_cycles(4);
        check("midcnt_before_reset", io_sw, 32'h20001);
        #1 rst = 1'b1;
        #1;
        check("async_reset_io_sw", io_sw, 32'h0);
        check("async_reset_pulses", {23'h0, press, release_p, sw_change}, 32'h0);
        #2 rst = 1'b0;
        clear_counts();
        run_cycles(5);
        check("requal_not_yet", io_sw, 32'h0);
        check("requal_no_change", 32'(swc), 32'h0);
        run_cycles(1);
        check("requal_io_sw", io_sw, 32'h20011);
        check("requal_change", 32'(swc), 32'h1);
        check("requal_io_btn", io_btn, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
